// File: rtl/haze_pass_sequencer_pkg.sv
// Shared types and constants for the two-pass haze frame sequencer.
package haze_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PASS1    = 3'd1,
        ST_WAIT_ALE = 3'd2,
        ST_ARM      = 3'd3,
        ST_PASS2    = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_t;

    // Bit positions inside the sticky error vector.
    localparam int ERR_CFG     = 0;
    localparam int ERR_TLAST   = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_ABORT   = 3;
    localparam int ERR_W       = 4;

    localparam int DIM_W_DEFAULT = 12;
    localparam int FRAME_CNT_W   = 2 * DIM_W_DEFAULT;

    // A frame geometry is usable when both dimensions are non-zero and the
    // line length is a whole number of 4-pixel groups.
    function automatic logic cfg_is_valid(input logic       width_nonzero,
                                          input logic       height_nonzero,
                                          input logic [1:0] width_low);
        return width_nonzero & height_nonzero & (width_low == 2'b00);
    endfunction

endpackage

// File: rtl/haze_pass_sequencer_if.sv
// Stream bundle: upstream DMA input, core S_AXIS output and core M_AXIS snoop.
interface haze_pass_sequencer_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic [DATA_W-1:0] core_tdata;
    logic              core_tvalid;
    logic              core_tlast;
    logic              core_tready;
    logic              out_tvalid;
    logic              out_tready;

    // Sequencer side.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, core_tready, out_tvalid, out_tready,
        output s_tready, core_tdata, core_tvalid, core_tlast
    );

    // Environment side (DMA, core and snooped output).
    modport master (
        output s_tdata, s_tvalid, s_tlast, core_tready, out_tvalid, out_tready,
        input  s_tready, core_tdata, core_tvalid, core_tlast
    );
endinterface

// File: rtl/haze_pass_sequencer_beat_counter.sv
// Beat counter with synchronous clear and a compare against a terminal value.
module haze_beat_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         at_term
);

    logic [W-1:0] count;

    // Count beats; clear wins over a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (inc) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/haze_pass_sequencer.sv
// Two-pass frame controller in front of the haze removal core: streams the
// frame once for ALE, waits for ale_done, enables the core and replays the
// frame, then counts output beats and reports completion or error on irq.
module haze_pass_sequencer
    import haze_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int DIM_W         = DIM_W_DEFAULT,
    parameter int ALE_TIMEOUT   = 1048576,
    parameter int DRAIN_TIMEOUT = 65536,
    parameter int ARM_CYCLES    = 4
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               start,
    input  logic               abort,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    output logic               dma_req,
    input  logic               ale_done,
    output logic               core_enable,
    output logic               busy,
    output logic               irq,
    output logic [ERR_W-1:0]   err,
    haze_pass_sequencer_if.slave strm
);

    localparam int CNT_W   = 2 * DIM_W;
    localparam int TMAX_AD = (ALE_TIMEOUT > DRAIN_TIMEOUT) ? ALE_TIMEOUT : DRAIN_TIMEOUT;
    localparam int TMAX    = (TMAX_AD > ARM_CYCLES) ? TMAX_AD : ARM_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t             state;
    state_t             next_raw;
    state_t             next_state;
    logic [CNT_W-1:0]   frame_n;
    logic [CNT_W-1:0]   frame_last;
    logic [TIMER_W-1:0] timer;
    logic [DATA_W-1:0]  pix;
    logic [ERR_W-1:0]   err_set;
    logic               timer_zero;
    logic               pass_active;
    logic               beat;
    logic               out_beat;
    logic               in_at_last;
    logic               out_at_n;
    logic               cfg_ok;
    logic               accept_start;
    logic               cfg_reject;
    logic               abort_evt;
    logic               enter_pass1;
    logic               enter_pass2;
    logic               enter_wait;
    logic               enter_arm;
    logic               enter_drain;
    logic               out_cnt_en;

    // Zero-latency passthrough, gated to the two streaming passes.
    assign pass_active      = (state == ST_PASS1) || (state == ST_PASS2);
    assign pix              = strm.s_tdata;
    assign strm.core_tdata  = pix;
    assign strm.core_tvalid = strm.s_tvalid & pass_active;
    assign strm.s_tready    = strm.core_tready & pass_active;
    assign strm.core_tlast  = pass_active & in_at_last;

    assign beat       = strm.s_tvalid & strm.core_tready & pass_active;
    assign out_beat   = strm.out_tvalid & strm.out_tready;
    assign frame_last = frame_n - CNT_W'(1);
    assign timer_zero = (timer == {TIMER_W{1'b0}});

    assign cfg_ok       = cfg_is_valid(cfg_width != {DIM_W{1'b0}},
                                       cfg_height != {DIM_W{1'b0}},
                                       cfg_width[1:0]);
    assign accept_start = (state == ST_IDLE) & start & ~abort & cfg_ok;
    assign cfg_reject   = (state == ST_IDLE) & start & ~abort & ~cfg_ok;
    assign abort_evt    = abort & (state != ST_IDLE);

    assign enter_pass1 = accept_start;
    assign enter_pass2 = (state == ST_ARM) && (next_state == ST_PASS2);
    assign enter_wait  = (state != ST_WAIT_ALE) && (next_state == ST_WAIT_ALE);
    assign enter_arm   = (state != ST_ARM) && (next_state == ST_ARM);
    assign enter_drain = (state != ST_DRAIN) && (next_state == ST_DRAIN);
    assign out_cnt_en  = out_beat & ((state == ST_PASS2) || (state == ST_DRAIN)) & ~out_at_n;

    haze_beat_counter #(.W(CNT_W)) u_in_cnt (
        .clk     (ACLK),
        .rst     (ARESET),
        .clear   (enter_pass1 | enter_pass2),
        .inc     (beat),
        .term    (frame_last),
        .at_term (in_at_last)
    );

    haze_beat_counter #(.W(CNT_W)) u_out_cnt (
        .clk     (ACLK),
        .rst     (ARESET),
        .clear   (enter_pass2),
        .inc     (out_cnt_en),
        .term    (frame_n),
        .at_term (out_at_n)
    );

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        next_raw = state;
        case (state)
            ST_IDLE: begin
                if (accept_start) next_raw = ST_PASS1;
                else              next_raw = ST_IDLE;
            end
            ST_PASS1: begin
                if (beat && in_at_last) next_raw = ST_WAIT_ALE;
                else                    next_raw = ST_PASS1;
            end
            ST_WAIT_ALE: begin
                if (ale_done)        next_raw = ST_ARM;
                else if (timer_zero) next_raw = ST_ERR;
                else                 next_raw = ST_WAIT_ALE;
            end
            ST_ARM: begin
                if (timer_zero) next_raw = ST_PASS2;
                else            next_raw = ST_ARM;
            end
            ST_PASS2: begin
                if (beat && in_at_last) next_raw = ST_DRAIN;
                else                    next_raw = ST_PASS2;
            end
            ST_DRAIN: begin
                if (out_at_n)                    next_raw = ST_DONE;
                else if (timer_zero && !out_beat) next_raw = ST_ERR;
                else                             next_raw = ST_DRAIN;
            end
            ST_DONE: next_raw = ST_IDLE;
            ST_ERR:  next_raw = ST_IDLE;
            default: next_raw = ST_IDLE;
        endcase
        next_state = abort_evt ? ST_IDLE : next_raw;
    end

    // Error events raised this cycle; merged into the sticky vector below.
    always_comb begin
        err_set              = 4'b0000;
        err_set[ERR_CFG]     = cfg_reject;
        err_set[ERR_TLAST]   = beat & (strm.s_tlast != in_at_last);
        err_set[ERR_TIMEOUT] = (next_state == ST_ERR);
        err_set[ERR_ABORT]   = abort_evt;
    end

    // Shared down-counter: ALE wait, arm hold and drain inactivity timers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            timer <= {TIMER_W{1'b0}};
        end else if (enter_wait) begin
            timer <= TIMER_W'(ALE_TIMEOUT - 1);
        end else if (enter_arm) begin
            timer <= TIMER_W'(ARM_CYCLES - 1);
        end else if (enter_drain || ((state == ST_DRAIN) && out_beat)) begin
            timer <= TIMER_W'(DRAIN_TIMEOUT - 1);
        end else if (!timer_zero) begin
            timer <= timer - TIMER_W'(1);
        end else begin
            timer <= timer;
        end
    end

    // Frame size latched when a frame is accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            frame_n <= {CNT_W{1'b0}};
        end else if (accept_start) begin
            frame_n <= CNT_W'(cfg_width) * CNT_W'(cfg_height);
        end else begin
            frame_n <= frame_n;
        end
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            dma_req     <= 1'b0;
            busy        <= 1'b0;
            core_enable <= 1'b0;
            irq         <= 1'b0;
            err         <= 4'b0000;
        end else begin
            dma_req     <= enter_pass1 | enter_pass2;
            busy        <= (next_state != ST_IDLE);
            core_enable <= (next_state == ST_ARM) || (next_state == ST_PASS2) ||
                           (next_state == ST_DRAIN);
            irq         <= (next_state == ST_DONE) || (next_state == ST_ERR) ||
                           abort_evt || cfg_reject;
            if (accept_start) begin
                err <= 4'b0000;
            end else begin
                err <= err | err_set;
            end
        end
    end

endmodule
